sensor_calib_ctrl: RTL
======================

Name: sensor_calib_ctrl

Overview:
Sequencer that calibrates the delay-line sensor by sweeping its IDC/IDF delay setting. For each setting it applies the configuration, waits for the line to settle, averages the Hamming weight of the sensor output and compares the average with a target. It stops at the first (smallest) delay code whose average is ≤ target and leaves that setting applied. It sits between the host/FSM and sensor_wrapper_top, in the sensor clock domain, and drives IDC_IDF / IDC_IDF_en.

Parameters:
SENSOR_WIDTH, 128, sensor output width in bits.
COARSE_WIDTH, 32, coarse thermometer-code bits (IDC_IDF[COARSE_WIDTH-1:0]).
FINE_WIDTH, 96, fine thermometer-code bits (IDC_IDF[127:COARSE_WIDTH]).
SETTLE_CYCLES, 16, wait cycles after each configuration update; must be ≥1.
LOG_AVG, 3, averaging window is N = 2^LOG_AVG samples.

Ports:
clk_i  in  1  sensor clock; only clock of the block.
rst  in  1  synchronous, active-high reset.
start_i  in  1  start a sweep; sampled only in IDLE.
abort_i  in  1  terminate the current sweep.
target_i  in  8  Hamming-weight threshold; latched on start.
sensor_i  in  SENSOR_WIDTH  raw sensor sample.
IDC_IDF_o  out  128  {fine thermometer, coarse thermometer}.
IDC_IDF_en_o  out  1  one-cycle load strobe for IDC_IDF_o.
busy_o  out  1  high from APPLY through EVAL.
done_o  out  1  one-cycle pulse when the sweep ends.
fail_o  out  1  sweep ended without a pass (no match or abort); held until the next start.
code_o  out  8  current/final delay code k.
avg_o  out  8  last averaged Hamming weight.

Behaviour:
- Reset: state IDLE; every output is 0; k=0; accumulator cleared.
- Code mapping:
  - c = min(k, COARSE_WIDTH), f = k − c; KMAX = COARSE_WIDTH + FINE_WIDTH (128).
  - Coarse bits [c-1:0] = 1; fine bits [COARSE_WIDTH+f-1:COARSE_WIDTH] = 1; all other bits 0.
- States:
  - IDLE: on start_i, latch target_i, set k=0, clear fail_o → APPLY.
  - APPLY (1 cycle): register IDC_IDF_o from k and assert IDC_IDF_en_o for exactly this cycle → SETTLE.
  - SETTLE: SETTLE_CYCLES cycles → ACCUM.
  - ACCUM: sample sensor_i on N consecutive cycles. Popcount is one registered stage, so the state lasts N+1 cycles. Sum width is 8+LOG_AVG and is cleared on ACCUM entry.
  - EVAL (1 cycle): avg_o = sum >> LOG_AVG (truncating).
    - avg ≤ target → DONE, pass.
    - else k = KMAX → DONE, fail_o=1.
    - else k+1 → APPLY.
  - DONE (1 cycle): done_o=1 → IDLE.
- Results: IDC_IDF_o and code_o hold their final values in IDLE.
- Timing: the start edge is cycle 0 and each step lasts S+N+3 cycles. For a pass at code k, done_o is high in cycle (k+1)(S+N+3)+1.
- start_i while busy is ignored.
- abort_i in any state except IDLE/DONE → DONE next cycle with fail_o=1. IDC_IDF_o holds the last applied value and no en strobe is issued. Abort wins over a simultaneous EVAL pass.
- rst mid-sweep: on the next edge everything returns to reset values. IDC_IDF_o becomes 0 but IDC_IDF_en_o stays 0; the sensor keeps its previous configuration until the next APPLY.

Test Plan:
- S=16, N=8 (27 cycles/step); model popcount 100 for k<5 and 40 for k≥5; target 64 → done_o in cycle 163, fail_o=0, code_o=5, avg_o=40, IDC_IDF_o=0x1F.
- Popcount constantly 120, target 10 → 129 en strobes, done_o with fail_o=1, code_o=128, IDC_IDF_o all ones.
- Averaging: samples alternating 60/70 with target 64 → avg 65, no pass at k=0. Alternating 60/68 → avg 64, pass at k=0 (equality passes).
- Pass at k=33 → IDC_IDF_o[31:0]=0xFFFFFFFF, IDC_IDF_o[32]=1, rest 0.
- abort_i in the 3rd ACCUM cycle of step k=2 → done_o next cycle, fail_o=1, code_o=2, no further en strobe. A start_i pulse during the sweep has no effect.
- rst asserted mid-SETTLE → all outputs 0 next cycle; a fresh start then sweeps from k=0 normally.

Source files
------------

// File: rtl/sensor_calib_ctrl.sv
// Delay-line sensor calibration sequencer: sweeps the IDC/IDF thermometer code upward and stops at
// the first code whose averaged Hamming weight is at or below the latched target.
module sensor_calib_ctrl #(
  parameter int unsigned SENSOR_WIDTH  = 128,
  parameter int unsigned COARSE_WIDTH  = 32,
  parameter int unsigned FINE_WIDTH    = 96,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOG_AVG       = 3
) (
  input  logic                                clk_i,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic                                abort_i,
  input  logic [7:0]                          target_i,
  input  logic [SENSOR_WIDTH-1:0]             sensor_i,
  output logic [COARSE_WIDTH+FINE_WIDTH-1:0]  IDC_IDF_o,
  output logic                                IDC_IDF_en_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                fail_o,
  output logic [7:0]                          code_o,
  output logic [7:0]                          avg_o
);

  localparam int unsigned KMAX  = COARSE_WIDTH + FINE_WIDTH;
  localparam int unsigned NAVG  = 1 << LOG_AVG;
  localparam int unsigned SUM_W = 8 + LOG_AVG;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + NAVG + 1);

  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AccumLast  = CNT_W'(NAVG);
  localparam logic [7:0]       KmaxCode   = 8'(KMAX);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StApply  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StAccum  = 3'd3;
  localparam logic [2:0] StEval   = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [7:0]        k_q, k_d;
  logic [7:0]        target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        pop_q, pop_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [7:0]        avg_q, avg_d;
  logic              fail_q, fail_d;
  logic [KMAX-1:0]   idc_q, idc_d;
  logic [7:0]        avg_w;
  logic              in_sweep;

  // Coarse bits fill first; fine bits take the remainder once the coarse field saturates.
  function automatic logic [KMAX-1:0] thermo(input logic [7:0] k);
    logic [KMAX-1:0] t;
    int c;
    int f;
    t = '0;
    c = (int'(k) < int'(COARSE_WIDTH)) ? int'(k) : int'(COARSE_WIDTH);
    f = int'(k) - c;
    for (int i = 0; i < int'(COARSE_WIDTH); i++) t[i] = (i < c);
    for (int j = 0; j < int'(FINE_WIDTH); j++) t[COARSE_WIDTH+j] = (j < f);
    return t;
  endfunction

  assign avg_w    = 8'(sum_q >> LOG_AVG);
  assign in_sweep = (state_q == StApply) || (state_q == StSettle) ||
                    (state_q == StAccum) || (state_q == StEval);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    pop_d    = pop_q;
    sum_d    = sum_q;
    avg_d    = avg_q;
    fail_d   = fail_q;
    idc_d    = idc_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          target_d = target_i;
          k_d      = '0;
          fail_d   = 1'b0;
          idc_d    = thermo(8'd0);
          state_d  = StApply;
        end
      end
      StApply: begin
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          sum_d   = '0;
          state_d = StAccum;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAccum: begin
        // Popcount is registered, so the sum trails sampling by one cycle.
        if (cnt_q < AccumLast) pop_d = 8'($countones(sensor_i));
        if (cnt_q != '0) sum_d = sum_q + SUM_W'(pop_q);
        if (cnt_q == AccumLast) begin
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEval: begin
        avg_d = avg_w;
        if (avg_w <= target_q) begin
          state_d = StDone;
        end else if (k_q == KmaxCode) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end else begin
          k_d     = k_q + 8'd1;
          idc_d   = thermo(k_q + 8'd1);
          state_d = StApply;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides any decision, including a pass in EVAL.
    if (abort_i && in_sweep) begin
      state_d = StDone;
      fail_d  = 1'b1;
      k_d     = k_q;
      idc_d   = idc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      pop_q    <= '0;
      sum_q    <= '0;
      avg_q    <= '0;
      fail_q   <= 1'b0;
      idc_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      pop_q    <= pop_d;
      sum_q    <= sum_d;
      avg_q    <= avg_d;
      fail_q   <= fail_d;
      idc_q    <= idc_d;
    end
  end

  assign IDC_IDF_o    = idc_q;
  assign IDC_IDF_en_o = (state_q == StApply);
  assign busy_o       = in_sweep;
  assign done_o       = (state_q == StDone);
  assign fail_o       = fail_q;
  assign code_o       = k_q;
  assign avg_o        = avg_q;

endmodule
